axi_ram_slave: RTL and testbench
================================

Name: axi_ram_slave

Overview:
AXI3-subset responder that models the memory end of the CPU's AXI master port. It accepts read and write bursts, including 4-beat INCR cache-line refills and writebacks and single-beat uncached accesses. It services exactly one transaction at a time from a word-addressed internal RAM. Its only use is as the simulation and FPGA stand-in slave connected to the AXI outputs of mycpu_top.

Parameters:
MEM_AW, 14, word-index width; RAM holds 2^MEM_AW 32-bit words; byte address bits [MEM_AW+1:2] select the word, upper bits ignored (aliasing).
RD_DELAY, 1, idle cycles between AR handshake and first rvalid (0 = rvalid on the cycle after the handshake).

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
arid  in  4  read ID
araddr  in  32  read start byte address
arlen  in  8  beats-1
arsize  in  3  ignored; full word always returned
arburst  in  2  00 FIXED, 01 INCR, others treated as INCR
arvalid  in  1  AR valid
arready  out  1  AR ready
rid  out  4  equals the accepted arid
rdata  out  32  read data
rresp  out  2  always 00 (OKAY)
rlast  out  1  final beat of the burst
rvalid  out  1  R valid
rready  in  1  R ready
awid  in  4  write ID
awaddr  in  32  write start byte address
awlen  in  8  beats-1
awsize  in  3  ignored; wstrb governs
awburst  in  2  same encoding as arburst
awvalid  in  1  AW valid
awready  out  1  AW ready
wid  in  4  ignored
wdata  in  32  write data
wstrb  in  4  byte enables
wlast  in  1  last write beat
wvalid  in  1  W valid
wready  out  1  W ready
bid  out  4  equals the accepted awid
bresp  out  2  00 OKAY / 10 SLVERR
bvalid  out  1  B valid
bready  in  1  B ready

Behaviour:
- Single clock aclk; asynchronous active-low reset aresetn.
- While reset is asserted, every output is 0, the FSM is forced to IDLE and the round-robin pointer prefers read. RAM contents are not reset.
- Reset asserted mid-burst aborts the transaction with no response. A RAM write is in progress only on a W handshake edge.
- FSM states: IDLE, RD_WAIT, RD_DATA, WR_DATA, WR_RESP.
- IDLE arbitration:
  - arready = arvalid & (~awvalid | pref_rd); awready = awvalid & (~arvalid | ~pref_rd).
  - Both are combinational from registered state and are never asserted outside IDLE.
  - On simultaneous arvalid and awvalid, the round-robin pointer picks; it flips to the other direction after each grant.
- AR handshake: latch arid, word address, arlen and burst type; clear the beat counter.
  - Go to RD_WAIT with the delay counter = RD_DELAY, or straight to RD_DATA when RD_DELAY = 0.
  - RD_WAIT decrements every cycle and enters RD_DATA when the counter reaches 0.
- RD_DATA:
  - rvalid = 1. rdata is the RAM word at the current address, registered on state entry and after each handshake.
  - rdata, rid and rlast stay stable while rvalid & ~rready.
  - rlast = (beat == arlen).
  - On each handshake: beat += 1; the address is incremented by 1 for INCR and held for FIXED, wrapping modulo 2^MEM_AW.
  - Handshake with rlast set -> IDLE.
- AW handshake: latch awid, address, awlen and burst type; clear the beat counter and the error flag; go to WR_DATA.
- WR_DATA:
  - wready = 1. Each handshake writes the bytes enabled by wstrb at the current address, then advances the address as for reads.
  - Beats with beat > awlen are dropped (no RAM write) and set the error flag.
  - wlast with beat < awlen sets the error flag.
  - A handshake with wlast set -> WR_RESP.
- WR_RESP: bvalid = 1; bresp = error ? 10 : 00; bid = latched awid; stable until bready. Handshake -> IDLE.
- Write-then-read to the same word returns the new data, because only one transaction is ever outstanding.
- Throughput:
  - INCR-4 read with RD_DELAY = 1 and rready held high: AR accepted at cycle 0, beats at cycles 2-5.
  - Back-to-back transactions incur one IDLE cycle.

Decomposition:
- Shared package axi_pkg:
  - burst encodings BURST_FIXED/BURST_INCR.
  - response codes RESP_OKAY/RESP_SLVERR.
  - the FSM state enum.
  - the 4-bit ID width constant.
- Sub-module axi_slave_ram_bank: single-port 2^MEM_AW x 32 RAM with 4-bit byte-write enable and registered read port. The FSM drives its address, write-enable and read-enable inputs.

Test Plan:
- Preload word 0x10 = 0xDEADBEEF; AR araddr=0x40, arlen=0, arid=3 -> single beat with rdata=0xDEADBEEF, rid=3, rlast=1, rresp=00, rvalid 2 cycles after the AR handshake.
- INCR-4 read at 0x100 over words 0xA0..0xA3, rready low on beats 1 and 3 for 2 cycles each -> data stays stable while stalled; rlast only on the 4th beat; return to IDLE.
- Write 0x11223344 with wstrb=1111, then 0xAABBCCDD with wstrb=0101 to 0x200, then read -> 0x11BB33DD; bresp=00, bid equal to awid.
- arvalid and awvalid asserted together from reset -> read granted first, write granted next; on a second collision the write wins (round-robin flip).
- awlen=1 with wlast on the 1st beat -> bresp=10; awlen=0 with 2 beats, wlast on the 2nd -> 2nd beat not written, bresp=10.
- FIXED read, arlen=3, at 0x40 -> four beats of the same word; aresetn pulsed low during beat 2 -> rvalid drops immediately, the next AR is accepted normally.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI encodings and the slave FSM state type.
package axi_pkg;

    localparam int ID_W = 4;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_RD_DATA,
        ST_WR_DATA,
        ST_WR_RESP
    } axi_state_e;

endpackage

// File: rtl/axi_slave_ram_bank.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// Contents are deliberately not reset.
module axi_slave_ram_bank #(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          re,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [3:0][7:0] mem [2**AW];

    // Byte-masked write and registered read; the FSM never does both at once.
    always_ff @(posedge clk) begin
        if (re)
            rdata <= mem[addr];
        for (int i = 0; i < 4; i++)
            if (we[i])
                mem[addr][i] <= wdata[8*i +: 8];
    end

endmodule

// File: rtl/axi_ram_slave.sv
// AXI3-subset memory responder: one transaction at a time, round-robin
// between read and write address channels, word-addressed internal RAM.
module axi_ram_slave
    import axi_pkg::*;
#(
    parameter int MEM_AW   = 14,
    parameter int RD_DELAY = 1
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [ID_W-1:0]  arid,
    input  logic [31:0]      araddr,
    input  logic [7:0]       arlen,
    input  logic [2:0]       arsize,
    input  logic [1:0]       arburst,
    input  logic             arvalid,
    output logic             arready,
    output logic [ID_W-1:0]  rid,
    output logic [31:0]      rdata,
    output logic [1:0]       rresp,
    output logic             rlast,
    output logic             rvalid,
    input  logic             rready,
    input  logic [ID_W-1:0]  awid,
    input  logic [31:0]      awaddr,
    input  logic [7:0]       awlen,
    input  logic [2:0]       awsize,
    input  logic [1:0]       awburst,
    input  logic             awvalid,
    output logic             awready,
    input  logic [ID_W-1:0]  wid,
    input  logic [31:0]      wdata,
    input  logic [3:0]       wstrb,
    input  logic             wlast,
    input  logic             wvalid,
    output logic             wready,
    output logic [ID_W-1:0]  bid,
    output logic [1:0]       bresp,
    output logic             bvalid,
    input  logic             bready
);

    localparam logic [7:0] DLY_INIT = 8'(RD_DELAY);

    axi_state_e        state;
    logic              pref_rd;
    logic [ID_W-1:0]   id_q;
    logic [7:0]        len_q;
    logic              fixed_q;
    logic [MEM_AW-1:0] addr_q;
    logic [8:0]        beat_q;   // one extra bit so overrun beats never alias back into range
    logic [7:0]        dly_q;
    logic              err_q;

    logic              ar_hs, aw_hs, r_hs, w_hs;
    logic              in_range;
    logic [MEM_AW-1:0] addr_nxt;
    logic [MEM_AW-1:0] ram_addr;
    logic              ram_re;
    logic [3:0]        ram_we;
    logic [31:0]       ram_q;

    logic unused_ok;
    assign unused_ok = ^{arsize, awsize, wid, araddr[31:MEM_AW+2], araddr[1:0],
                         awaddr[31:MEM_AW+2], awaddr[1:0]};

    // Address-channel arbitration only in IDLE; reset gates everything to 0.
    assign arready = aresetn & (state == ST_IDLE) & arvalid & (~awvalid | pref_rd);
    assign awready = aresetn & (state == ST_IDLE) & awvalid & (~arvalid | ~pref_rd);
    assign rvalid  = (state == ST_RD_DATA);
    assign wready  = (state == ST_WR_DATA);
    assign bvalid  = (state == ST_WR_RESP);

    assign rid     = id_q;
    assign bid     = id_q;
    assign rdata   = rvalid ? ram_q : 32'h0;
    assign rresp   = RESP_OKAY;
    assign rlast   = rvalid & (beat_q == {1'b0, len_q});
    assign bresp   = (bvalid & err_q) ? RESP_SLVERR : RESP_OKAY;

    assign ar_hs    = arvalid & arready;
    assign aw_hs    = awvalid & awready;
    assign r_hs     = rvalid & rready;
    assign w_hs     = wvalid & wready;
    assign in_range = (beat_q <= {1'b0, len_q});
    assign addr_nxt = fixed_q ? addr_q : addr_q + MEM_AW'(1);

    // RAM port steering: prefetch the first word on RD_DATA entry, the next
    // word on each read handshake, byte writes on in-range W beats.
    always_comb begin
        ram_addr = addr_q;
        ram_re   = 1'b0;
        ram_we   = 4'b0;
        case (state)
            ST_IDLE: begin
                ram_addr = araddr[MEM_AW+1:2];
                ram_re   = (RD_DELAY == 0) && ar_hs;
            end
            ST_RD_WAIT: ram_re = (dly_q <= 8'd1);
            ST_RD_DATA: begin
                if (r_hs && !rlast) begin
                    ram_addr = addr_nxt;
                    ram_re   = 1'b1;
                end
            end
            ST_WR_DATA: ram_we = (w_hs && in_range) ? wstrb : 4'b0;
            default: ;
        endcase
    end

    axi_slave_ram_bank #(.AW(MEM_AW)) u_bank (
        .clk   (aclk),
        .addr  (ram_addr),
        .re    (ram_re),
        .we    (ram_we),
        .wdata (wdata),
        .rdata (ram_q)
    );

    // Transaction FSM with burst bookkeeping and round-robin pointer.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= ST_IDLE;
            pref_rd <= 1'b1;
            id_q    <= '0;
            len_q   <= '0;
            fixed_q <= 1'b0;
            addr_q  <= '0;
            beat_q  <= '0;
            dly_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ar_hs) begin
                        id_q    <= arid;
                        len_q   <= arlen;
                        fixed_q <= (arburst == BURST_FIXED);
                        addr_q  <= araddr[MEM_AW+1:2];
                        beat_q  <= '0;
                        dly_q   <= DLY_INIT;
                        pref_rd <= 1'b0;
                        state   <= (RD_DELAY == 0) ? ST_RD_DATA : ST_RD_WAIT;
                    end else if (aw_hs) begin
                        id_q    <= awid;
                        len_q   <= awlen;
                        fixed_q <= (awburst == BURST_FIXED);
                        addr_q  <= awaddr[MEM_AW+1:2];
                        beat_q  <= '0;
                        err_q   <= 1'b0;
                        pref_rd <= 1'b1;
                        state   <= ST_WR_DATA;
                    end
                end
                ST_RD_WAIT: begin
                    dly_q <= dly_q - 8'd1;
                    if (dly_q <= 8'd1)
                        state <= ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    if (r_hs) begin
                        beat_q <= beat_q + 9'd1;
                        addr_q <= addr_nxt;
                        if (rlast)
                            state <= ST_IDLE;
                    end
                end
                ST_WR_DATA: begin
                    if (w_hs) begin
                        addr_q <= addr_nxt;
                        if (beat_q != 9'h1FF)
                            beat_q <= beat_q + 9'd1;
                        if (!in_range || (wlast && beat_q < {1'b0, len_q}))
                            err_q <= 1'b1;
                        if (wlast)
                            state <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (bready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Scoreboard bench for axi_ram_slave: driver pushes expected R/B responses,
// a negedge monitor drives rready/bready and checks every presented beat.
module tb_axi_ram_slave;
    import axi_pkg::*;

    logic        aclk = 1'b0, aresetn = 1'b0;
    logic [3:0]  arid = '0, awid = '0, wid = '0, rid, bid;
    logic [31:0] araddr = '0, awaddr = '0, wdata = '0, rdata;
    logic [7:0]  arlen = '0, awlen = '0;
    logic [2:0]  arsize = '0, awsize = '0;
    logic [1:0]  arburst = '0, awburst = '0, rresp, bresp;
    logic        arvalid = 1'b0, awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
    logic [3:0]  wstrb = '0;
    logic        arready, awready, wready, rvalid, rlast, bvalid;
    logic        rready, bready;

    typedef struct { logic [31:0] data; logic [3:0] id; logic last; } rexp_t;
    typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;
    rexp_t rq[$];
    bexp_t bq[$];

    int checks = 0, errors = 0;
    bit stall_en = 1'b0;

    always #5 aclk = ~aclk;

    axi_ram_slave #(.MEM_AW(14), .RD_DELAY(1)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: handshake decisions and comparisons happen on the falling edge.
    initial begin
        int beat_idx;
        int stall_cnt;
        beat_idx = 0;
        stall_cnt = 0;
        rready = 1'b1;
        bready = 1'b1;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                rq.delete();
                bq.delete();
                beat_idx = 0;
                stall_cnt = 0;
                rready = 1'b1;
            end else begin
                if (rvalid) begin
                    if (stall_en && (beat_idx == 1 || beat_idx == 3) && stall_cnt < 2) begin
                        rready = 1'b0;
                        stall_cnt++;
                    end else begin
                        rready = 1'b1;
                    end
                    checks++;
                    if (rq.size() == 0) begin
                        errors++;
                        $display("FAIL r_unexpected: rdata %h rid %0d with nothing expected", rdata, rid);
                    end else begin
                        if ({rdata, rid, rlast, rresp} !== {rq[0].data, rq[0].id, rq[0].last, 2'b00}) begin
                            errors++;
                            $display("FAIL r_beat: got data %h id %0d last %b resp %b, expected data %h id %0d last %b resp 00",
                                     rdata, rid, rlast, rresp, rq[0].data, rq[0].id, rq[0].last);
                        end
                        if (rready) begin
                            void'(rq.pop_front());
                            beat_idx = rlast ? 0 : beat_idx + 1;
                            stall_cnt = 0;
                        end
                    end
                end else begin
                    rready = 1'b1;
                end
                if (bvalid) begin
                    checks++;
                    if (bq.size() == 0) begin
                        errors++;
                        $display("FAIL b_unexpected: bid %0d bresp %b with nothing expected", bid, bresp);
                    end else begin
                        if ({bid, bresp} !== {bq[0].id, bq[0].resp}) begin
                            errors++;
                            $display("FAIL b_resp: got id %0d resp %b, expected id %0d resp %b",
                                     bid, bresp, bq[0].id, bq[0].resp);
                        end
                        void'(bq.pop_front());
                    end
                end
            end
        end
    end

    task automatic ar_send(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        bit ok;
        ok = 1'b0;
        arid = id; araddr = addr; arlen = len; arburst = burst; arsize = 3'd2; arvalid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge aclk);
            if (arready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL ar_timeout: arready low for id %0d, expected a grant", id);
        end
        @(posedge aclk); #1;
        arvalid = 1'b0;
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        bit ok;
        ok = 1'b0;
        awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = 3'd2; awvalid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge aclk);
            if (awready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL aw_timeout: awready low for id %0d, expected a grant", id);
        end
        @(posedge aclk); #1;
        awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
        bit ok;
        ok = 1'b0;
        wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge aclk);
            if (wready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL w_timeout: wready low for data %h, expected ready", data);
        end
        @(posedge aclk); #1;
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic wr_single(input logic [3:0] id, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] strb);
        bq.push_back('{id: id, resp: 2'b00});
        aw_send(id, addr, 8'd0, BURST_INCR);
        w_send(data, strb, 1'b1);
    endtask

    task automatic push_r(input logic [31:0] data, input logic [3:0] id, input logic last);
        rq.push_back('{data: data, id: id, last: last});
    endtask

    task automatic wait_drain(input string name);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(posedge aclk); #1;
            if (rq.size() == 0 && bq.size() == 0) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL %s_drain: %0d R and %0d B responses outstanding, expected 0", name, rq.size(), bq.size());
        end
    endtask

    task automatic do_reset();
        @(posedge aclk); #1;
        aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
    endtask

    // Directed stimulus.
    initial begin
        // Reset state, with both address valids pushed high to prove the gating.
        arvalid = 1'b1; awvalid = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_rvalid",  32'(rvalid),  32'd0);
        chk("rst_bvalid",  32'(bvalid),  32'd0);
        chk("rst_wready",  32'(wready),  32'd0);
        chk("rst_rdata_rlast_bresp", {rdata[27:0], rlast, 1'b0, bresp}, 32'd0);
        arvalid = 1'b0; awvalid = 1'b0;
        aresetn = 1'b1;
        @(posedge aclk); #1;

        // Single-beat read with latency check.
        wr_single(4'd1, 32'h40, 32'hDEADBEEF, 4'hF);
        wait_drain("wr40");
        push_r(32'hDEADBEEF, 4'd3, 1'b1);
        ar_send(4'd3, 32'h40, 8'd0, BURST_INCR);
        chk("rd1_rvalid_cyc1", 32'(rvalid), 32'd0);
        @(posedge aclk); #1;
        chk("rd1_rvalid_cyc2", 32'(rvalid), 32'd1);
        wait_drain("rd1");

        // INCR-4 write, then INCR-4 read with stalls on beats 1 and 3.
        bq.push_back('{id: 4'd2, resp: 2'b00});
        aw_send(4'd2, 32'h100, 8'd3, BURST_INCR);
        for (int i = 0; i < 4; i++)
            w_send(32'hA0 + 32'(i), 4'hF, i == 3);
        wait_drain("wr_burst");
        stall_en = 1'b1;
        for (int i = 0; i < 4; i++)
            push_r(32'hA0 + 32'(i), 4'd5, i == 3);
        ar_send(4'd5, 32'h100, 8'd3, BURST_INCR);
        wait_drain("rd_burst");
        stall_en = 1'b0;

        // Byte-strobe merge.
        wr_single(4'd6, 32'h200, 32'h11223344, 4'b1111);
        wr_single(4'd7, 32'h200, 32'hAABBCCDD, 4'b0101);
        wait_drain("wr_strb");
        push_r(32'h11BB33DD, 4'd8, 1'b1);
        ar_send(4'd8, 32'h200, 8'd0, BURST_INCR);
        wait_drain("rd_strb");

        // Collision from reset: read first, then a fresh AR collides and write wins.
        do_reset();
        arid = 4'd9;  araddr = 32'h200; arlen = 8'd0; arburst = BURST_INCR; arvalid = 1'b1;
        awid = 4'd10; awaddr = 32'h300; awlen = 8'd0; awburst = BURST_INCR; awvalid = 1'b1;
        push_r(32'h11BB33DD, 4'd9, 1'b1);
        @(negedge aclk);
        chk("coll1_arready", 32'(arready), 32'd1);
        chk("coll1_awready", 32'(awready), 32'd0);
        @(posedge aclk); #1;
        arid = 4'd11;
        push_r(32'h11BB33DD, 4'd11, 1'b1);
        begin
            bit seen;
            seen = 1'b0;
            for (int n = 0; n < 30; n++) begin
                @(negedge aclk);
                if (arready || awready) begin seen = 1'b1; break; end
            end
            chk("coll2_grant_seen", 32'(seen), 32'd1);
        end
        chk("coll2_awready", 32'(awready), 32'd1);
        chk("coll2_arready", 32'(arready), 32'd0);
        bq.push_back('{id: 4'd10, resp: 2'b00});
        @(posedge aclk); #1;
        awvalid = 1'b0;
        w_send(32'h5555AAAA, 4'hF, 1'b1);
        ar_send(4'd11, 32'h200, 8'd0, BURST_INCR);
        wait_drain("collision");

        // Early wlast on a 2-beat burst, and an overrun beat on a 1-beat FIXED burst.
        bq.push_back('{id: 4'd12, resp: 2'b10});
        aw_send(4'd12, 32'h400, 8'd1, BURST_INCR);
        w_send(32'hCAFE0001, 4'hF, 1'b1);
        bq.push_back('{id: 4'd13, resp: 2'b10});
        aw_send(4'd13, 32'h500, 8'd0, BURST_FIXED);
        w_send(32'h12345678, 4'hF, 1'b0);
        w_send(32'h99999999, 4'hF, 1'b1);
        wait_drain("wr_err");
        push_r(32'h12345678, 4'd14, 1'b1);
        ar_send(4'd14, 32'h500, 8'd0, BURST_INCR);
        wait_drain("rd_overrun");

        // FIXED 4-beat read aborted by reset during beat 2, then a normal read.
        for (int i = 0; i < 4; i++)
            push_r(32'hDEADBEEF, 4'd15, i == 3);
        ar_send(4'd15, 32'h40, 8'd3, BURST_FIXED);
        begin
            bit at_beat2;
            at_beat2 = 1'b0;
            for (int n = 0; n < 40; n++) begin
                @(posedge aclk); #1;
                if (rq.size() == 2) begin at_beat2 = 1'b1; break; end
            end
            chk("fixed_reached_beat2", 32'(at_beat2), 32'd1);
        end
        chk("fixed_beat2_rvalid", 32'(rvalid), 32'd1);
        aresetn = 1'b0;
        #1;
        chk("abort_rvalid", 32'(rvalid), 32'd0);
        chk("abort_rdata", rdata, 32'd0);
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        @(posedge aclk); #1;
        push_r(32'hDEADBEEF, 4'd1, 1'b1);
        ar_send(4'd1, 32'h40, 8'd0, BURST_INCR);
        wait_drain("post_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
